// File: rtl/dataflow_op_unit.sv
// dataflow_op_unit: two-stage pipelined data-flow operator engine.
// Stage 1 captures opcode/operands on an accepted input, stage 2 holds the
// computed result. Both stages use valid/ready handshakes with full
// backpressure. A saturating counter tallies completed output transfers.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer holds valid and its payload stable
// until the transfer. in_ready does not depend on in_valid.
//
// Optional build macro DFO_FLAGS_EN adds registered out_zero / out_parity
// flags computed from the stage-2 result.
module dataflow_op_unit #(
   parameter int WIDTH = 4,
   parameter int REP   = 8,
   parameter int CNT_W = 16,
   localparam int OUT_W = WIDTH * REP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_err,
`ifdef DFO_FLAGS_EN
   output logic             out_zero,
   output logic             out_parity,
`endif
   output logic [CNT_W-1:0] txn_count
);

   // in_ready is held low until the first clock after reset release
   logic             init_q, init_d;

   logic             s1_valid_q, s1_valid_d;
   logic [3:0]       s1_op_q, s1_op_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;

   logic             s2_valid_q, s2_valid_d;
   logic [OUT_W-1:0] s2_data_q, s2_data_d;
   logic             s2_err_q, s2_err_d;
`ifdef DFO_FLAGS_EN
   logic             s2_zero_q, s2_zero_d;
   logic             s2_parity_q, s2_parity_d;
`endif

   logic [CNT_W-1:0] txn_q, txn_d;

   logic             s2_adv;
   logic             s1_adv;
   logic             in_fire;
   logic             out_fire;
   logic [OUT_W-1:0] res;
   logic             res_err;

   // Advance conditions: a stage may load when it is empty or its content leaves
   always_comb begin
      s2_adv   = !s2_valid_q || out_ready;
      s1_adv   = !s1_valid_q || s2_adv;
      in_ready = init_q && s1_adv;
      in_fire  = in_valid && in_ready;
      out_fire = s2_valid_q && out_ready;
   end

   // Operator evaluation on the stage-1 contents, zero-extended to OUT_W
   always_comb begin
      res     = '0;
      res_err = 1'b0;
      case (s1_op_q)
         4'd0: res[WIDTH-1:0] = s1_a_q & s1_b_q;
         4'd1: res[WIDTH-1:0] = s1_a_q | s1_b_q;
         4'd2: res[WIDTH-1:0] = s1_a_q ^ s1_b_q;
         4'd3: res[0] = (|s1_a_q) && (|s1_b_q);
         4'd4: res[0] = (|s1_a_q) || (|s1_b_q);
         4'd5: res[0] = &s1_a_q;
         4'd6: res[0] = |s1_a_q;
         4'd7: res[0] = ^s1_a_q;
         4'd8: res[2*WIDTH-1:0] = {s1_a_q, s1_b_q};
         4'd9: res = {REP{s1_a_q}};
         default: res_err = 1'b1;
      endcase
   end

   // Next-state for both pipeline stages and the transfer counter
   always_comb begin
      init_d     = 1'b1;
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_err_d   = s2_err_q;
`ifdef DFO_FLAGS_EN
      s2_zero_d   = s2_zero_q;
      s2_parity_d = s2_parity_q;
`endif
      txn_d      = txn_q;

      if (s1_adv) begin
         s1_valid_d = in_fire;
         if (in_fire) begin
            s1_op_d = in_op;
            s1_a_d  = in_a;
            s1_b_d  = in_b;
         end
      end

      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_data_d = res;
            s2_err_d  = res_err;
`ifdef DFO_FLAGS_EN
            s2_zero_d   = (res == '0);
            s2_parity_d = ^res;
`endif
         end
      end

      if (out_fire && (txn_q != {CNT_W{1'b1}})) begin
         txn_d = txn_q + CNT_W'(1);
      end
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_q     <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_err_q   <= 1'b0;
`ifdef DFO_FLAGS_EN
         s2_zero_q   <= 1'b0;
         s2_parity_q <= 1'b0;
`endif
         txn_q      <= '0;
      end else begin
         init_q     <= init_d;
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_err_q   <= s2_err_d;
`ifdef DFO_FLAGS_EN
         s2_zero_q   <= s2_zero_d;
         s2_parity_q <= s2_parity_d;
`endif
         txn_q      <= txn_d;
      end
   end

   // Outputs come straight from stage-2 registers
   always_comb begin
      out_valid = s2_valid_q;
      out_data  = s2_data_q;
      out_err   = s2_err_q;
`ifdef DFO_FLAGS_EN
      out_zero   = s2_zero_q;
      out_parity = s2_parity_q;
`endif
      txn_count = txn_q;
   end

endmodule

// File: tb/tb_dataflow_op_unit.sv
// Bench for dataflow_op_unit: directed literal cases, a stall scenario,
// randomized traffic against a transaction-level model, and a narrow-counter
// instance for saturation and mid-flight reset. Build with +define+DFO_FLAGS_EN
// to also cover the flag outputs.
module tb_dataflow_op_unit;

   localparam int WIDTH = 4;
   localparam int REP   = 8;
   localparam int OUT_W = WIDTH * REP;
   localparam int CNT_W = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // main instance signals
   logic             in_valid, in_ready, out_valid, out_ready, out_err;
   logic [3:0]       in_op;
   logic [WIDTH-1:0] in_a, in_b;
   logic [OUT_W-1:0] out_data;
   logic [CNT_W-1:0] txn_count;

   // narrow-counter instance signals
   logic             c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_err;
   logic [3:0]       c_in_op;
   logic [WIDTH-1:0] c_in_a, c_in_b;
   logic [OUT_W-1:0] c_out_data;
   logic [1:0]       c_txn;

`ifdef DFO_FLAGS_EN
   logic out_zero, out_parity, c_out_zero, c_out_parity;
`endif

   dataflow_op_unit #(.WIDTH(WIDTH), .REP(REP), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_err(out_err),
`ifdef DFO_FLAGS_EN
      .out_zero(out_zero), .out_parity(out_parity),
`endif
      .txn_count(txn_count)
   );

   dataflow_op_unit #(.WIDTH(WIDTH), .REP(REP), .CNT_W(2)) dut_c (
      .clk(clk), .rst_n(rst_n),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_op(c_in_op),
      .in_a(c_in_a), .in_b(c_in_b),
      .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_data(c_out_data), .out_err(c_out_err),
`ifdef DFO_FLAGS_EN
      .out_zero(c_out_zero), .out_parity(c_out_parity),
`endif
      .txn_count(c_txn)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // returns {err, data}
   function automatic logic [OUT_W:0] model(input logic [3:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
      logic [OUT_W-1:0] d;
      int ones;
      d = '0;
      ones = 0;
      for (int i = 0; i < WIDTH; i++) ones += int'(a[i]);
      case (op)
         4'd0: d = OUT_W'(a & b);
         4'd1: d = OUT_W'(a | b);
         4'd2: d = OUT_W'(a ^ b);
         4'd3: d = OUT_W'((a != 0) && (b != 0));
         4'd4: d = OUT_W'((a != 0) || (b != 0));
         4'd5: d = OUT_W'(ones == WIDTH);
         4'd6: d = OUT_W'(ones != 0);
         4'd7: d = OUT_W'(ones % 2);
         4'd8: d = OUT_W'(a) * (OUT_W'(1) << WIDTH) + OUT_W'(b);
         4'd9: for (int i = 0; i < REP; i++) d = (d << WIDTH) + OUT_W'(a);
         default: return {1'b1, {OUT_W{1'b0}}};
      endcase
      return {1'b0, d};
   endfunction

   // ---------------- scoreboard ----------------
   logic [OUT_W:0] exp_q[$];   // {err, data} of results in flight, oldest first
   int             exp_t_q[$]; // clock edge at which each was accepted
   int             edge_n = 0;
   int             model_cnt = 0;
   logic           prev_rst = 1'b0;

   always @(posedge clk) edge_n <= edge_n + 1;

   // Compare process: checks main instance every cycle, then advances the model
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_in_ready", in_ready, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_data", out_data, 0);
         chk("rst_out_err", out_err, 0);
         chk("rst_txn", txn_count, 0);
`ifdef DFO_FLAGS_EN
         chk("rst_flags", {out_zero, out_parity}, 0);
`endif
         exp_q.delete();
         exp_t_q.delete();
         model_cnt = 0;
      end else begin
         chk("in_ready", in_ready, prev_rst && ((exp_q.size() < 2) || out_ready));
         chk("out_valid", out_valid, (exp_q.size() > 0) && (edge_n >= exp_t_q[0] + 1));
         if (out_valid && exp_q.size() > 0) begin
            chk("out_data", out_data, exp_q[0][OUT_W-1:0]);
            chk("out_err", out_err, exp_q[0][OUT_W]);
`ifdef DFO_FLAGS_EN
            chk("out_zero", out_zero, exp_q[0][OUT_W-1:0] == 0);
            chk("out_parity", out_parity, ^exp_q[0][OUT_W-1:0]);
`endif
         end
         chk("txn_count", txn_count, model_cnt);
         if (out_valid && out_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(exp_t_q.pop_front());
            if (model_cnt < (1 << CNT_W) - 1) model_cnt++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_op, in_a, in_b));
            exp_t_q.push_back(edge_n + 1);
         end
      end
      prev_rst = rst_n;
   end

   // transfers seen on the narrow-counter instance
   int c_fires = 0;
   always @(negedge clk) begin
      if (!rst_n) c_fires = 0;
      else if (c_out_valid && c_out_ready) c_fires++;
   end

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // one isolated transaction with out_ready=1, checking exact latency
   task automatic send_check(input string name, input logic [3:0] op,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [OUT_W-1:0] exp_d, input logic exp_e);
      cycle();
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
      @(negedge clk);
      chk({name, "_in_ready"}, in_ready, 1);
      cycle();
      in_valid = 1'b0;
      @(negedge clk);
      chk({name, "_lat1"}, out_valid, 0);
      cycle();
      @(negedge clk);
      chk({name, "_valid"}, out_valid, 1);
      chk({name, "_data"}, out_data, exp_d);
      chk({name, "_err"}, out_err, exp_e);
`ifdef DFO_FLAGS_EN
      if (op == 4'd12) begin
         chk({name, "_zero"}, out_zero, 1);
         chk({name, "_parity"}, out_parity, 0);
      end
`endif
      cycle();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic f;
      int   idx, acc;
      rst_n = 1'b0;
      in_valid = 0; in_op = 0; in_a = 0; in_b = 0; out_ready = 0;
      c_in_valid = 0; c_in_op = 0; c_in_a = 0; c_in_b = 0; c_out_ready = 0;

      // model pinned by hand-computed values
      chk("model_and", model(4'd0, 4'b1011, 4'b1111), 33'h0_0000000B);
      chk("model_cat", model(4'd8, 4'b1110, 4'b1010), 33'h0_000000EA);
      chk("model_repl", model(4'd9, 4'b1010, 4'b0000), 33'h0_AAAAAAAA);
      chk("model_ill", model(4'd12, 4'b1111, 4'b1111), 33'h1_00000000);

      repeat (3) cycle();
      rst_n = 1'b1;
      out_ready = 1'b1;

      // back-to-back AND, OR, XOR -> consecutive results
      in_a = 4'b1011; in_b = 4'b1111;
      cycle(); in_valid = 1'b1; in_op = 4'd0;
      cycle(); in_op = 4'd1;
      cycle(); in_op = 4'd2;
      @(negedge clk);
      chk("b2b_r0_valid", out_valid, 1);
      chk("b2b_r0", out_data, 32'h0000000B);
      cycle(); in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_r1_valid", out_valid, 1);
      chk("b2b_r1", out_data, 32'h0000000F);
      cycle();
      @(negedge clk);
      chk("b2b_r2_valid", out_valid, 1);
      chk("b2b_r2", out_data, 32'h00000004);
      cycle();
      @(negedge clk);
      chk("b2b_empty", out_valid, 0);
      chk("b2b_txn", txn_count, 3);

      // isolated operator cases
      send_check("op0", 4'd0, 4'b1011, 4'b1111, 32'h0000000B, 1'b0);
      send_check("op3", 4'd3, 4'b1011, 4'b1111, 32'h00000001, 1'b0);
      send_check("op5", 4'd5, 4'b1101, 4'b0000, 32'h00000000, 1'b0);
      send_check("op8", 4'd8, 4'b1110, 4'b1010, 32'h000000EA, 1'b0);
      send_check("op9", 4'd9, 4'b1010, 4'b0000, 32'hAAAAAAAA, 1'b0);
      send_check("op12", 4'd12, 4'b1111, 4'b0101, 32'h00000000, 1'b1);

      // stall: three inputs offered while the sink is blocked for 5 cycles
      out_ready = 1'b0;
      in_a = 4'b1011; in_b = 4'b1111;
      cycle();
      idx = 0; acc = 0;
      in_valid = 1'b1; in_op = 4'd0;
      repeat (5) begin
         @(negedge clk);
         f = in_valid && in_ready;
         if (f) acc++;
         cycle();
         if (f) begin
            idx++;
            if (idx < 3) in_op = 4'(idx); else in_valid = 1'b0;
         end
      end
      @(negedge clk);
      chk("stall_accepts", acc, 2);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_hold", out_data, 32'h0000000B);
      cycle();
      out_ready = 1'b1;
      for (int k = 0; k < 12 && (idx < 3 || exp_q.size() > 0); k++) begin
         @(negedge clk);
         f = in_valid && in_ready;
         cycle();
         if (f) begin
            idx++;
            if (idx < 3) in_op = 4'(idx); else in_valid = 1'b0;
         end
      end
      chk("stall_all_in", idx, 3);
      chk("stall_drained", exp_q.size(), 0);

      // randomized traffic with one mid-run reset
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         f = in_valid && in_ready;
         cycle();
         if (i == 200) begin
            rst_n = 1'b0;
            in_valid = 1'b0;
            cycle();
            cycle();
            rst_n = 1'b1;
         end else begin
            out_ready = ($urandom_range(0, 9) < 7);
            if (!in_valid || f) begin
               in_valid = ($urandom_range(0, 3) != 0);
               in_op = 4'($urandom_range(0, 15));
               in_a = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
               in_b = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            end
         end
      end
      @(negedge clk);
      f = in_valid && in_ready;
      cycle();
      if (f) in_valid = 1'b0;
      for (int k = 0; k < 30 && (in_valid || exp_q.size() > 0); k++) begin
         out_ready = 1'b1;
         @(negedge clk);
         f = in_valid && in_ready;
         cycle();
         if (f) in_valid = 1'b0;
      end
      chk("rand_drained", exp_q.size(), 0);

      // narrow counter: five transfers saturate at 3
      c_out_ready = 1'b1;
      c_in_a = 4'b0011; c_in_b = 4'b0101; c_in_op = 4'd2;
      c_in_valid = 1'b1;
      repeat (5) cycle();
      c_in_valid = 1'b0;
      repeat (4) cycle();
      @(negedge clk);
      chk("cnt2_transfers", c_fires, 5);
      chk("cnt2_sat", c_txn, 3);

      // fill both stages, then reset mid-flight
      cycle();
      c_out_ready = 1'b0;
      c_in_valid = 1'b1;
      cycle();
      cycle();
      c_in_valid = 1'b0;
      @(negedge clk);
      chk("cnt2_full_valid", c_out_valid, 1);
      chk("cnt2_full_ready", c_in_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("cnt2_rst_valid", c_out_valid, 0);
      chk("cnt2_rst_txn", c_txn, 0);
      cycle();
      cycle();
      rst_n = 1'b1;
      c_out_ready = 1'b1;
      idx = 0;
      repeat (6) begin
         @(negedge clk);
         if (c_out_valid) idx++;
      end
      chk("cnt2_no_ghost", idx, 0);
      chk("cnt2_txn_after", c_txn, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dataflow_op_unit.md
Name: dataflow_op_unit

Overview:
- Parametrised, pipelined operator engine for data-flow operators: bitwise, logical, reduction, concatenation, replication.
- Takes two WIDTH-bit operands and a 4-bit opcode over a valid/ready handshake.
- Returns a registered OUT_W-bit result two cycles later with full backpressure.
- Sits between the operand sequencer and result sink in the ADSD datapath labs; also counts completed transactions.

Parameters:
- WIDTH, 4, operand width in bits (>=1).
- REP, 8, replication factor; OUT_W = WIDTH*REP; REP >= 2 so that {a,b} fits.
- CNT_W, 16, width of the saturating transaction counter.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode present.
- in_ready  out  1  unit accepts when in_valid && in_ready.
- in_op  in  4  opcode.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  result present.
- out_ready  in  1  sink accepts when out_valid && out_ready.
- out_data  out  OUT_W  result, zero-extended.
- out_err  out  1  result came from an illegal opcode.
- txn_count  out  CNT_W  completed output transfers, saturating.

Behaviour:
- Reset: one asynchronous reset, active-low, on rst_n; one clock, clk.
  - While rst_n=0: in_ready=0, out_valid=0, out_data=0, out_err=0, txn_count=0, both stage valids cleared.
  - in_ready rises the first cycle after rst_n deasserts.
- Stage 1 (S1) registers op/a/b on an accepted input.
- Stage 2 (S2) registers the computed result.
- out_data, out_err and out_valid come directly from S2 registers.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational, no dependency on in_valid).
- Latency: 2 cycles from acceptance to out_valid, with no stall.
- Throughput: 1 transfer/cycle with out_ready held at 1.
- Stall: while out_valid && !out_ready, out_data and out_err hold stable and no data is lost or duplicated.
  - With both stages full, in_ready=0.
- Opcodes (results zero-extended to OUT_W):
  - 0 AND a&b; 1 OR a|b; 2 XOR a^b.
  - 3 LAND a&&b in bit0; 4 LOR a||b in bit0.
  - 5 RAND &a; 6 ROR |a; 7 RXOR ^a (bit0).
  - 8 CAT {a,b} in bits [2*WIDTH-1:0]; 9 REPL {REP{a}}, full OUT_W.
  - 10-15 illegal: out_data=0, out_err=1.
- txn_count increments by 1 on each out_valid && out_ready and saturates at all-ones; it never wraps.
- Simultaneous events: input accept and output drain in the same cycle are both honoured; the pipeline stays full.
- Reset mid-operation: all in-flight results are discarded with no output; txn_count returns to 0.

Optional Feature:
- Macro: DFO_FLAGS_EN.
- Defined: adds ports out_zero (out, 1) and out_parity (out, 1).
  - Registered in S2 alongside out_data.
  - out_zero = (out_data == 0); out_parity = ^out_data.
  - Both reset to 0 and hold during stalls.
- Not defined: the ports and their logic are absent; all other behaviour is identical.

Test Plan (WIDTH=4, REP=8, OUT_W=32 unless noted):
- op0, a=4'b1011, b=4'b1111 -> out_data=0x0000000B after 2 cycles, out_err=0. op3 with same operands -> 0x00000001.
- op5, a=4'b1101 -> 0x00000000. op8, a=4'b1110, b=4'b1010 -> 0x000000EA. op9, a=4'b1010 -> 0xAAAAAAAA.
- Back-to-back ops 0,1,2 with out_ready=1 -> three results on consecutive cycles; txn_count=3.
- out_ready=0 for 5 cycles with 3 inputs offered:
  - out_data holds the first result.
  - in_ready drops after 2 accepts.
  - After releasing out_ready, results arrive in order with none lost.
- op12 -> out_data=0, out_err=1; with DFO_FLAGS_EN, out_zero=1 and out_parity=0.
- CNT_W=2: five transfers -> txn_count stops at 3.
  - Then rst_n=0 with both stages full -> out_valid=0 immediately and txn_count=0, with no output after release.
